// File: rtl/pkg.sv
//------------------------------------------------------------------------------
// Module      : pkg
// Description : Shared numeric parameters for the systolic array datapath.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pkg;
    localparam int NUM_BITS = 16;
endpackage

`default_nettype wire

// File: rtl/systolic_drain_if.sv
//------------------------------------------------------------------------------
// Module      : systolic_drain_if
// Description : Skewed column stream in, aligned row handshake and status out.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface systolic_drain_if #(
    parameter int N     = 4,
    parameter int DEPTH = 4
);
    logic [N*pkg::NUM_BITS-1:0]  bottom_i;
    logic [N-1:0]                valid_i;
    logic [N*pkg::NUM_BITS-1:0]  row_o;
    logic                        row_valid_o;
    logic                        row_ready_i;
    logic [$clog2(DEPTH+1)-1:0]  space_o;
    logic                        overflow_o;
    logic                        skew_err_o;
    logic                        clear_i;

    modport master (
        output bottom_i, valid_i, row_ready_i, clear_i,
        input  row_o, row_valid_o, space_o, overflow_o, skew_err_o
    );

    modport slave (
        input  bottom_i, valid_i, row_ready_i, clear_i,
        output row_o, row_valid_o, space_o, overflow_o, skew_err_o
    );
endinterface

`default_nettype wire

// File: rtl/systolic_drain.sv
//------------------------------------------------------------------------------
// Module      : systolic_drain
// Description : Deskews the last PE row's partial sums and queues whole rows.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module systolic_drain #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input wire             clk_i,
    input wire             rst_i,
    systolic_drain_if.slave bus
);
    localparam int c_W  = pkg::NUM_BITS;
    localparam int c_RW = N * c_W;
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [N-1:0][c_W-1:0] w_al_data;
    logic [N-1:0]          w_al_vld;

    // Column j waits N-1-j cycles so every element of a row meets column N-1.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int c_DLY = N - 1 - j;
        if (c_DLY == 0) begin : g_pass
            assign w_al_data[j] = bus.bottom_i[j*c_W +: c_W];
            assign w_al_vld[j]  = bus.valid_i[j];
        end else begin : g_dly
            logic [c_W-1:0]   r_dly_data [c_DLY];
            logic [c_DLY-1:0] r_dly_vld;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_dly_vld <= '0;
                    for (int k = 0; k < c_DLY; k++) begin
                        r_dly_data[k] <= '0;
                    end
                end else begin
                    r_dly_vld[0]  <= bus.valid_i[j];
                    r_dly_data[0] <= bus.bottom_i[j*c_W +: c_W];
                    for (int k = 1; k < c_DLY; k++) begin
                        r_dly_vld[k]  <= r_dly_vld[k-1];
                        r_dly_data[k] <= r_dly_data[k-1];
                    end
                end
            end

            assign w_al_data[j] = r_dly_data[c_DLY-1];
            assign w_al_vld[j]  = r_dly_vld[c_DLY-1];
        end
    end

    logic [c_RW-1:0] r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic            r_skew_err;

    logic w_push_req;
    logic w_misalign;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_push_req = &w_al_vld;
    assign w_misalign = (|w_al_vld) && !(&w_al_vld);
    assign w_full     = (r_count == c_CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && bus.row_ready_i;
    // A full FIFO still takes a row when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_al_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error in the same cycle as a clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_i) begin
                r_overflow <= 1'b0;
            end
            if (w_misalign) begin
                r_skew_err <= 1'b1;
            end else if (bus.clear_i) begin
                r_skew_err <= 1'b0;
            end
        end
    end

    assign bus.row_valid_o = !w_empty;
    assign bus.row_o       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.space_o     = c_CW'(DEPTH) - r_count;
    assign bus.overflow_o  = r_overflow;
    assign bus.skew_err_o  = r_skew_err;

endmodule

`default_nettype wire

// File: tb/tb_systolic_drain.sv
//------------------------------------------------------------------------------
// Module      : tb_systolic_drain
// Description : Directed self-checking bench for the systolic output collector.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_systolic_drain;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    systolic_drain_if #(.N(N), .DEPTH(DEPTH)) bus ();

    systolic_drain #(.N(N), .DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] exp_row(input logic [15:0] base, input int r);
        logic [63:0] v;
        for (int j = 0; j < N; j++) begin
            v[j*16 +: 16] = base + 16'(r * 256) + 16'(j);
        end
        return v;
    endfunction

    // Drives nrows skewed rows; element j of row r goes out in cycle r+j.
    task automatic feed(input int nrows, input logic [15:0] base, input int bad_row,
                        input int bad_col, input int rdy_cyc, input int clr_cyc,
                        input bit chk_pre);
        for (int c = 0; c < nrows + N - 1; c++) begin
            for (int j = 0; j < N; j++) begin
                int r;
                r = c - j;
                if (r >= 0 && r < nrows) begin
                    bus.bottom_i[j*16 +: 16] = base + 16'(r * 256) + 16'(j);
                    bus.valid_i[j]           = !(r == bad_row && j == bad_col);
                end else begin
                    bus.bottom_i[j*16 +: 16] = '0;
                    bus.valid_i[j]           = 1'b0;
                end
            end
            bus.row_ready_i = (c == rdy_cyc);
            bus.clear_i     = (c == clr_cyc);
            if (chk_pre && c == nrows + N - 2) begin
                chk("pre_latency_valid", 64'(bus.row_valid_o), 64'd0);
            end
            step();
        end
        bus.bottom_i    = '0;
        bus.valid_i     = '0;
        bus.row_ready_i = 1'b0;
        bus.clear_i     = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
    endtask

    initial begin
        bus.bottom_i    = '0;
        bus.valid_i     = '0;
        bus.row_ready_i = 1'b0;
        bus.clear_i     = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst_i = 1'b1;
        #1;
        chk("rst_valid", 64'(bus.row_valid_o), 64'd0);
        chk("rst_row",   bus.row_o,            64'd0);
        chk("rst_space", 64'(bus.space_o),     64'd4);
        chk("rst_ovf",   64'(bus.overflow_o),  64'd0);
        chk("rst_skew",  64'(bus.skew_err_o),  64'd0);
        step();
        rst_i = 1'b0;
        step();

        // Single row
        feed(1, 16'h0010, -1, -1, -1, -1, 1'b1);
        chk("single_valid", 64'(bus.row_valid_o), 64'd1);
        chk("single_row",   bus.row_o,            64'h0013_0012_0011_0010);
        chk("single_space", 64'(bus.space_o),     64'd3);
        step();
        chk("single_hold",  bus.row_o,            64'h0013_0012_0011_0010);
        bus.row_ready_i = 1'b1;
        step();
        bus.row_ready_i = 1'b0;
        chk("single_pop_valid", 64'(bus.row_valid_o), 64'd0);
        chk("single_pop_space", 64'(bus.space_o),     64'd4);
        chk("single_pop_row",   bus.row_o,            64'd0);

        // Overflow: five rows into a four-row FIFO
        feed(5, 16'h0000, -1, -1, -1, -1, 1'b0);
        chk("ovf_space", 64'(bus.space_o),    64'd0);
        chk("ovf_flag",  64'(bus.overflow_o), 64'd1);
        chk("ovf_head",  bus.row_o,           64'h0003_0002_0001_0000);
        for (int r = 0; r < 4; r++) begin
            chk("ovf_drain", bus.row_o, exp_row(16'h0000, r));
            bus.row_ready_i = 1'b1;
            step();
        end
        bus.row_ready_i = 1'b0;
        chk("ovf_empty_valid", 64'(bus.row_valid_o), 64'd0);
        chk("ovf_empty_space", 64'(bus.space_o),     64'd4);
        chk("ovf_sticky",      64'(bus.overflow_o),  64'd1);
        pulse_clear();
        chk("ovf_cleared",     64'(bus.overflow_o),  64'd0);

        // Full FIFO with push and pop in the same cycle
        feed(5, 16'h0020, -1, -1, 7, -1, 1'b0);
        chk("pp_space", 64'(bus.space_o),    64'd0);
        chk("pp_ovf",   64'(bus.overflow_o), 64'd0);
        for (int r = 1; r < 5; r++) begin
            chk("pp_drain", bus.row_o, exp_row(16'h0020, r));
            bus.row_ready_i = 1'b1;
            step();
        end
        bus.row_ready_i = 1'b0;
        chk("pp_empty", 64'(bus.row_valid_o), 64'd0);

        // Skew error: column 2 missing its valid
        feed(1, 16'h0030, 0, 2, -1, -1, 1'b0);
        chk("skew_space", 64'(bus.space_o),     64'd4);
        chk("skew_valid", 64'(bus.row_valid_o), 64'd0);
        chk("skew_flag",  64'(bus.skew_err_o),  64'd1);
        pulse_clear();
        chk("skew_clear", 64'(bus.skew_err_o),  64'd0);
        feed(1, 16'h0040, 0, 2, -1, 3, 1'b0);
        chk("skew_set_wins", 64'(bus.skew_err_o), 64'd1);
        chk("skew2_space",   64'(bus.space_o),    64'd4);
        pulse_clear();
        chk("skew_clear2",   64'(bus.skew_err_o), 64'd0);

        // Reset while a row is half-way in
        bus.valid_i = 4'b0001;
        bus.bottom_i[15:0] = 16'h0050;
        step();
        bus.valid_i = 4'b0010;
        bus.bottom_i = '0;
        bus.bottom_i[31:16] = 16'h0051;
        step();
        rst_i = 1'b1;
        bus.valid_i = '0;
        bus.bottom_i = '0;
        #1;
        chk("midrst_space", 64'(bus.space_o),     64'd4);
        chk("midrst_valid", 64'(bus.row_valid_o), 64'd0);
        #1 rst_i = 1'b0;
        bus.valid_i = 4'b0100;
        bus.bottom_i[47:32] = 16'h0052;
        step();
        bus.valid_i = 4'b1000;
        bus.bottom_i = '0;
        bus.bottom_i[63:48] = 16'h0053;
        step();
        bus.valid_i = '0;
        bus.bottom_i = '0;
        for (int k = 0; k < 4; k++) begin
            chk("midrst_no_row", 64'(bus.row_valid_o), 64'd0);
            step();
        end
        chk("midrst_skew",  64'(bus.skew_err_o), 64'd1);
        chk("midrst_space2", 64'(bus.space_o),   64'd4);
        chk("midrst_row",   bus.row_o,           64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
